// File: rtl/note_buffer_if.sv
// note_buffer_if: strobe, key and playback signals between the controller side and the note buffer.
interface note_buffer_if #(
   parameter int DEPTH = 16,
   parameter int KEY_W = 4
);
   logic                     enable_shift;
   logic                     enable_read;
   logic                     key_valid;
   logic [KEY_W-1:0]         key_code;
   logic                     play_start;
   logic                     play_stop;
   logic                     clear;
   logic [KEY_W-1:0]         note_out;
   logic                     note_valid;
   logic                     playing;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     empty;
   logic                     overflow;
   modport master (
      output enable_shift, enable_read, key_valid, key_code, play_start, play_stop, clear,
      input  note_out, note_valid, playing, count, full, empty, overflow
   );
   modport slave (
      input  enable_shift, enable_read, key_valid, key_code, play_start, play_stop, clear,
      output note_out, note_valid, playing, count, full, empty, overflow
   );
endinterface

// File: rtl/note_buffer.sv
// note_buffer: circular FIFO that records key codes on write slots and replays them on read slots.
module note_buffer #(
   parameter int DEPTH = 16,
   parameter int KEY_W = 4
) (
   input logic          clk,
   input logic          resetn,
   note_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {S_IDLE, S_PLAY} state_t;
   state_t           state, state_nxt;
   logic [KEY_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [KEY_W-1:0] note_out;
   logic             note_valid, overflow, full, empty, wr, rd;
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign wr    = bus.enable_shift & bus.key_valid & ~full & ~bus.clear;
   // Reads only drain stored entries; an empty buffer never forwards a same-cycle write.
   assign rd    = bus.enable_read & (state == S_PLAY) & ~empty & ~bus.clear;
   always_ff @(posedge clk)
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   always_comb begin
      state_nxt = state;
      if (bus.clear)
         state_nxt = S_IDLE;
      else if (state == S_IDLE)
         state_nxt = (bus.play_start & ~bus.play_stop & ~empty) ? S_PLAY : S_IDLE;
      else
         state_nxt = (bus.play_stop | (empty & ~wr)) ? S_IDLE : S_PLAY;
   end
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= bus.key_code;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         note_out   <= '0;
         note_valid <= 1'b0;
         overflow   <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         note_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         if (rd) note_out <= mem[rd_ptr];
         count      <= count + (AW+1)'(wr) - (AW+1)'(rd);
         note_valid <= rd;
         if (bus.enable_shift & bus.key_valid & full) overflow <= 1'b1;
      end
   end
   assign bus.note_out   = note_out;
   assign bus.note_valid = note_valid;
   assign bus.playing    = state == S_PLAY;
   assign bus.count      = count;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.overflow   = overflow;
endmodule

// File: tb/tb_note_buffer.sv
// tb_note_buffer: directed record/playback sequences against hand-computed expectations.
module tb_note_buffer;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   note_buffer_if #(.DEPTH(16), .KEY_W(4)) bus ();
   note_buffer #(.DEPTH(16), .KEY_W(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic idle_inputs();
      bus.enable_shift = 1'b0;
      bus.enable_read  = 1'b0;
      bus.key_valid    = 1'b0;
      bus.key_code     = '0;
      bus.play_start   = 1'b0;
      bus.play_stop    = 1'b0;
      bus.clear        = 1'b0;
   endtask
   task automatic write_key(input int k);
      bus.enable_shift = 1'b1;
      bus.key_valid    = 1'b1;
      bus.key_code     = 4'(k);
      tick();
      bus.enable_shift = 1'b0;
      bus.key_valid    = 1'b0;
   endtask
   task automatic pulse_start();
      bus.play_start = 1'b1;
      tick();
      bus.play_start = 1'b0;
   endtask
   task automatic pulse_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask
   task automatic read_expect(input string tag, input int k);
      bus.enable_read = 1'b1;
      tick();
      bus.enable_read = 1'b0;
      chk({tag, "_valid"}, 32'(bus.note_valid), 32'd1);
      chk({tag, "_note"}, 32'(bus.note_out), 32'(k & 15));
   endtask
   initial begin
      idle_inputs();
      tick();
      tick();
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_playing", 32'(bus.playing), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_note", 32'(bus.note_out), 32'd0);
      chk("rst_valid", 32'(bus.note_valid), 32'd0);
      resetn = 1'b1;
      // 1: record three keys
      write_key(3);
      chk("t1_valid0", 32'(bus.note_valid), 32'd0);
      write_key(7);
      chk("t1_valid1", 32'(bus.note_valid), 32'd0);
      write_key(1);
      chk("t1_valid2", 32'(bus.note_valid), 32'd0);
      chk("t1_count", 32'(bus.count), 32'd3);
      chk("t1_empty", 32'(bus.empty), 32'd0);
      // 2: alternating slots with no key pressed
      pulse_start();
      chk("t2_playing", 32'(bus.playing), 32'd1);
      bus.enable_shift = 1'b1; tick(); bus.enable_shift = 1'b0;
      read_expect("t2_r0", 3);
      bus.enable_shift = 1'b1; tick(); bus.enable_shift = 1'b0;
      chk("t2_pulse", 32'(bus.note_valid), 32'd0);
      read_expect("t2_r1", 7);
      bus.enable_shift = 1'b1; tick(); bus.enable_shift = 1'b0;
      read_expect("t2_r2", 1);
      chk("t2_count", 32'(bus.count), 32'd0);
      tick();
      chk("t2_stopped", 32'(bus.playing), 32'd0);
      chk("t2_empty", 32'(bus.empty), 32'd1);
      // 3: overfill by two
      for (int i = 0; i < 15; i++) write_key(i);
      chk("t3_full15", 32'(bus.full), 32'd0);
      write_key(15);
      chk("t3_full16", 32'(bus.full), 32'd1);
      chk("t3_count16", 32'(bus.count), 32'd16);
      chk("t3_ovf_pre", 32'(bus.overflow), 32'd0);
      write_key(16);
      write_key(17);
      chk("t3_count", 32'(bus.count), 32'd16);
      chk("t3_overflow", 32'(bus.overflow), 32'd1);
      pulse_start();
      for (int i = 0; i < 16; i++) read_expect($sformatf("t3_r%0d", i), i);
      tick();
      chk("t3_stopped", 32'(bus.playing), 32'd0);
      chk("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
      pulse_clear();
      chk("t3_ovf_clr", 32'(bus.overflow), 32'd0);
      // 4: pointer wrap across two batches
      for (int i = 0; i < 10; i++) write_key(i + 2);
      pulse_start();
      for (int i = 0; i < 10; i++) read_expect($sformatf("t4a_r%0d", i), i + 2);
      tick();
      chk("t4_idle", 32'(bus.playing), 32'd0);
      for (int i = 0; i < 10; i++) write_key(15 - i);
      chk("t4_count", 32'(bus.count), 32'd10);
      pulse_start();
      for (int i = 0; i < 10; i++) read_expect($sformatf("t4b_r%0d", i), 15 - i);
      // 5: simultaneous write and read
      pulse_clear();
      for (int i = 0; i < 5; i++) write_key(9 + i);
      pulse_start();
      bus.enable_shift = 1'b1; bus.key_valid = 1'b1; bus.key_code = 4'd2; bus.enable_read = 1'b1;
      tick();
      idle_inputs();
      chk("t5_count", 32'(bus.count), 32'd5);
      chk("t5_valid", 32'(bus.note_valid), 32'd1);
      chk("t5_note", 32'(bus.note_out), 32'd9);
      read_expect("t5_r1", 10);
      read_expect("t5_r2", 11);
      read_expect("t5_r3", 12);
      read_expect("t5_r4", 13);
      read_expect("t5_r5", 2);
      chk("t5_drained", 32'(bus.count), 32'd0);
      // 6: clear during playback
      for (int i = 0; i < 17; i++) write_key(i);
      chk("t6_ovf", 32'(bus.overflow), 32'd1);
      pulse_start();
      for (int i = 0; i < 12; i++) read_expect($sformatf("t6_r%0d", i), i);
      chk("t6_count4", 32'(bus.count), 32'd4);
      bus.enable_read = 1'b1;
      pulse_clear();
      bus.enable_read = 1'b0;
      chk("t6_count", 32'(bus.count), 32'd0);
      chk("t6_playing", 32'(bus.playing), 32'd0);
      chk("t6_overflow", 32'(bus.overflow), 32'd0);
      chk("t6_valid", 32'(bus.note_valid), 32'd0);
      chk("t6_hold", 32'(bus.note_out), 32'd11);
      pulse_start();
      chk("t6_start_ign", 32'(bus.playing), 32'd0);
      // stop wins over start; reset aborts playback
      write_key(5);
      write_key(6);
      bus.play_start = 1'b1; bus.play_stop = 1'b1;
      tick();
      idle_inputs();
      chk("stop_prio", 32'(bus.playing), 32'd0);
      pulse_start();
      read_expect("rst_mid_r", 5);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("rst_mid_play", 32'(bus.playing), 32'd0);
      chk("rst_mid_count", 32'(bus.count), 32'd0);
      chk("rst_mid_note", 32'(bus.note_out), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
